// File: rtl/reg32_ad_pkg.sv
// Shared constants and types for the reg32_ad register bank.
//   DATA_W    : width of every register and data bus
//   ADDR_W    : width of the write line select
//   NUM_REGS  : register count (2**ADDR_W)
//   RESET_VAL : value every register takes under reset
//   word_t    : one register word
//   dec_line  : guarded one-hot write decode
package reg32_ad_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000;

  typedef logic [DATA_W-1:0] word_t;

  // One-hot decode of the write line. The comparison is evaluated per line,
  // so an X/Z on the select makes every compare unknown, which an 'if' treats
  // as false: no line is selected and nothing gets written.
  function automatic logic [NUM_REGS-1:0] dec_line(input logic en,
                                                   input logic [ADDR_W-1:0] line);
    logic [NUM_REGS-1:0] hot;
    hot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (line == ADDR_W'(i))) hot[i] = 1'b1;
    end
    return hot;
  endfunction
endpackage

// File: rtl/reg32_ad_cell.sv
// Single register cell of the reg32_ad bank.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear to RESET_VAL
//   load  : capture d at the next rising edge
//   d     : write data
//   q     : current register content
module reg32_ad_cell
  import reg32_ad_pkg::*;
#(
  parameter int DATA_W = reg32_ad_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= DATA_W'(RESET_VAL);
    else if (load) q <= d;
  end

endmodule

// File: rtl/reg32_ad_bank.sv
// Bank of 16 independent registers, each with its own data_in bus and its own
// parallel data_out bus. One register is written per cycle, selected by
// add_line while write_en is high; all registers are readable at once.
//   clk                    : rising-edge clock
//   reset                  : asynchronous active-high, clears every register
//   write_en               : write strobe
//   add_line               : register written (0..15)
//   data_in0..data_in15    : per-register write data
//   data_out0..data_out15  : per-register content
// Build option REG32_AD_WRITE_THROUGH_EN: the addressed output shows its
// data_in combinationally while a write is pending. Without it the outputs
// are purely registered.
// Register count is tied to the 16 discrete port pairs; ADDR_W must stay 4.
module reg32_ad_bank
  import reg32_ad_pkg::*;
#(
  parameter int DATA_W = reg32_ad_pkg::DATA_W,
  parameter int ADDR_W = reg32_ad_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] add_line,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic [DATA_W-1:0] data_in5,
  input  logic [DATA_W-1:0] data_in6,
  input  logic [DATA_W-1:0] data_in7,
  input  logic [DATA_W-1:0] data_in8,
  input  logic [DATA_W-1:0] data_in9,
  input  logic [DATA_W-1:0] data_in10,
  input  logic [DATA_W-1:0] data_in11,
  input  logic [DATA_W-1:0] data_in12,
  input  logic [DATA_W-1:0] data_in13,
  input  logic [DATA_W-1:0] data_in14,
  input  logic [DATA_W-1:0] data_in15,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [DATA_W-1:0] data_out4,
  output logic [DATA_W-1:0] data_out5,
  output logic [DATA_W-1:0] data_out6,
  output logic [DATA_W-1:0] data_out7,
  output logic [DATA_W-1:0] data_out8,
  output logic [DATA_W-1:0] data_out9,
  output logic [DATA_W-1:0] data_out10,
  output logic [DATA_W-1:0] data_out11,
  output logic [DATA_W-1:0] data_out12,
  output logic [DATA_W-1:0] data_out13,
  output logic [DATA_W-1:0] data_out14,
  output logic [DATA_W-1:0] data_out15
);

  logic [NUM_REGS-1:0][DATA_W-1:0] din;
  logic [NUM_REGS-1:0][DATA_W-1:0] q;
  logic [NUM_REGS-1:0][DATA_W-1:0] dout;
  logic [NUM_REGS-1:0]             hot;

  // Port fan-in to a packed array so the cells can be generated.
  assign din[0]  = data_in0;
  assign din[1]  = data_in1;
  assign din[2]  = data_in2;
  assign din[3]  = data_in3;
  assign din[4]  = data_in4;
  assign din[5]  = data_in5;
  assign din[6]  = data_in6;
  assign din[7]  = data_in7;
  assign din[8]  = data_in8;
  assign din[9]  = data_in9;
  assign din[10] = data_in10;
  assign din[11] = data_in11;
  assign din[12] = data_in12;
  assign din[13] = data_in13;
  assign din[14] = data_in14;
  assign din[15] = data_in15;

  // Reset is folded into the decode so write-through is also suppressed
  // while reset is held; the cells clear asynchronously regardless.
  assign hot = dec_line(write_en & ~reset, add_line);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    reg32_ad_cell #(.DATA_W(DATA_W)) u_cell (
      .clk  (clk),
      .reset(reset),
      .load (hot[i]),
      .d    (din[i]),
      .q    (q[i])
    );

`ifdef REG32_AD_WRITE_THROUGH_EN
    assign dout[i] = hot[i] ? din[i] : q[i];
`else
    assign dout[i] = q[i];
`endif
  end

  assign data_out0  = dout[0];
  assign data_out1  = dout[1];
  assign data_out2  = dout[2];
  assign data_out3  = dout[3];
  assign data_out4  = dout[4];
  assign data_out5  = dout[5];
  assign data_out6  = dout[6];
  assign data_out7  = dout[7];
  assign data_out8  = dout[8];
  assign data_out9  = dout[9];
  assign data_out10 = dout[10];
  assign data_out11 = dout[11];
  assign data_out12 = dout[12];
  assign data_out13 = dout[13];
  assign data_out14 = dout[14];
  assign data_out15 = dout[15];

endmodule

// File: tb/tb_reg32_ad_bank.sv
// Directed self-checking bench for reg32_ad_bank. Inputs change just after
// the falling edge; outputs are sampled at falling edges (mid-cycle).
module tb_reg32_ad_bank;
  import reg32_ad_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [3:0]  add_line;
  word_t       din [16];
  wire  [31:0] dout [16];
  word_t       exp_q [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg32_ad_bank dut (
    .clk(clk), .reset(reset), .write_en(write_en), .add_line(add_line),
    .data_in0(din[0]),   .data_in1(din[1]),   .data_in2(din[2]),   .data_in3(din[3]),
    .data_in4(din[4]),   .data_in5(din[5]),   .data_in6(din[6]),   .data_in7(din[7]),
    .data_in8(din[8]),   .data_in9(din[9]),   .data_in10(din[10]), .data_in11(din[11]),
    .data_in12(din[12]), .data_in13(din[13]), .data_in14(din[14]), .data_in15(din[15]),
    .data_out0(dout[0]),   .data_out1(dout[1]),   .data_out2(dout[2]),   .data_out3(dout[3]),
    .data_out4(dout[4]),   .data_out5(dout[5]),   .data_out6(dout[6]),   .data_out7(dout[7]),
    .data_out8(dout[8]),   .data_out9(dout[9]),   .data_out10(dout[10]), .data_out11(dout[11]),
    .data_out12(dout[12]), .data_out13(dout[13]), .data_out14(dout[14]), .data_out15(dout[15])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", tag, i), dout[i], exp_q[i]);
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b1;
    add_line = 4'd0;
    for (int i = 0; i < 16; i++) begin
      din[i]   = 32'hFFFF_FFFF;
      exp_q[i] = 32'h0;
    end

    // Reset held 20ns with writes attempted: nothing may load.
    #1 chk_all("rst_t1");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_all($sformatf("rst_edge%0d", c));
      add_line = add_line + 4'd7;
    end

    // Single write to line 2, other buses left at all-ones.
    reset    = 1'b0;
    add_line = 4'd2;
    din[2]   = 32'h0000_FFFF;
    write_en = 1'b1;
    #1;
`ifdef REG32_AD_WRITE_THROUGH_EN
    chk("wt_pre_edge", dout[2], 32'h0000_FFFF);
`else
    chk("wt_pre_edge", dout[2], 32'h0000_0000);
`endif
    chk("wt_other", dout[3], 32'h0);
    @(negedge clk);
    write_en = 1'b0;
    exp_q[2] = 32'h0000_FFFF;
    #1 chk_all("single");

    // Isolation: only line 5 loads, neighbour bus ignored.
    add_line = 4'd5;
    din[5]   = 32'hA5A5_A5A5;
    din[6]   = 32'h1234_5678;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    exp_q[5] = 32'hA5A5_A5A5;
    #1 chk_all("isolate");

    // Hold: write_en low, everything else churns.
    for (int c = 0; c < 16; c++) begin
      add_line = 4'(c);
      for (int i = 0; i < 16; i++) din[i] = $urandom;
      @(negedge clk);
    end
    #1 chk_all("hold");

    // Back-to-back writes to one line: newest value each edge.
    add_line = 4'd7;
    din[7]   = 32'h1111_1111;
    write_en = 1'b1;
    @(negedge clk);
    chk("rewrite_first", dout[7], 32'h1111_1111);
    din[7] = 32'h2222_2222;
    @(negedge clk);
    write_en = 1'b0;
    exp_q[7] = 32'h2222_2222;
    #1 chk("rewrite_second", dout[7], 32'h2222_2222);

    // Full sweep.
    for (int i = 0; i < 16; i++) begin
      add_line = 4'(i);
      din[i]   = 32'hC0DE_0000 + 32'(i);
      write_en = 1'b1;
      @(negedge clk);
      exp_q[i] = 32'hC0DE_0000 + 32'(i);
    end
    write_en = 1'b0;
    #1 chk_all("sweep");

    // Async reset between edges, with a write pending across the edge.
    #1;
    reset    = 1'b1;
    add_line = 4'd3;
    din[3]   = 32'hDEAD_BEEF;
    write_en = 1'b1;
    for (int i = 0; i < 16; i++) exp_q[i] = 32'h0;
    #1 chk_all("async_rst");
    @(negedge clk);
    reset    = 1'b0;
    write_en = 1'b0;
    #1 chk_all("rst_write_lost");

    // Bank writable again after reset.
    add_line = 4'd9;
    din[9]   = 32'h9999_0009;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    exp_q[9] = 32'h9999_0009;
    #1 chk_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
